// File: rtl/ps2_field_entry_if.sv
// Scan-code byte stream from PS2_Controller into the field-entry block.
// The byte is only meaningful in a cycle where data_en is high.
interface ps2_field_entry_if;
  logic [7:0] data;
  logic       data_en;

  modport master (output data, output data_en);
  modport slave  (input  data, input  data_en);
endinterface

// File: rtl/ps2_field_entry.sv
// PS/2 numeric-entry front end: a function key selects a field, digits fill a BCD buffer,
// and Enter commits it through a fixed-latency BCD-to-binary conversion and range check.
module ps2_field_entry #(
  parameter int NUM_FIELDS = 3,
  parameter int DIGITS     = 3,
  parameter int VAL_W      = 10,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 999
) (
  input  logic                        CLOCK_50,
  input  logic                        nReset,
  ps2_field_entry_if.slave            ps2,
  output logic [NUM_FIELDS*VAL_W-1:0] values,
  output logic [NUM_FIELDS-1:0]       field_valid,
  output logic                        editing,
  output logic [1:0]                  active_field,
  output logic [4*DIGITS-1:0]         digits_bcd,
  output logic [DIGITS-1:0]           digit_blank,
  output logic                        commit,
  output logic [1:0]                  commit_field,
  output logic                        range_error
);

  localparam int BW = 4 * DIGITS;
  localparam logic [2:0]       DIG_N = 3'(DIGITS);
  localparam logic [VAL_W-1:0] MIN_V = VAL_W'(MIN_VAL);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, EDIT, CONVERT, CHECK} state_t;

  // {hit, value}
  function automatic logic [4:0] digit_decode(input logic [7:0] code);
    case (code)
      8'h45: return {1'b1, 4'd0};
      8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};
      8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};
      8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};
      8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};
      8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // {hit, field index} for F1..F4
  function automatic logic [2:0] fkey_decode(input logic [7:0] code);
    case (code)
      8'h05: return {1'b1, 2'd0};
      8'h06: return {1'b1, 2'd1};
      8'h04: return {1'b1, 2'd2};
      8'h0C: return {1'b1, 2'd3};
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] bcd_mac(input logic [VAL_W-1:0] acc, input logic [3:0] nib);
    logic [VAL_W+3:0] w;
    w = {4'd0, acc} * (VAL_W+4)'(10) + (VAL_W+4)'(nib);
    return w[VAL_W-1:0];
  endfunction

  function automatic logic in_range(input logic [VAL_W-1:0] acc);
    return (acc >= MIN_V) && (acc <= MAX_V);
  endfunction

  state_t                      state_q, state_d;
  logic                        brk_q, brk_d, ext_q, ext_d;
  logic [1:0]                  active_q, active_d;
  logic [BW-1:0]               buf_q, buf_d, sh_q, sh_d;
  logic [2:0]                  cnt_q, cnt_d, cyc_q, cyc_d;
  logic [VAL_W-1:0]            acc_q, acc_d;
  logic [NUM_FIELDS*VAL_W-1:0] values_q, values_d;
  logic [NUM_FIELDS-1:0]       fvalid_q, fvalid_d;
  logic                        commit_q, commit_d, rerr_q, rerr_d;
  logic [1:0]                  cfield_q, cfield_d;

  logic       make_vld;
  logic [4:0] dig;
  logic [2:0] fk;
  logic       fk_ok;

  // Break/extended prefixes swallow the byte that follows them
  assign make_vld = ps2.data_en && (ps2.data != 8'hF0) && (ps2.data != 8'hE0) && !brk_q && !ext_q;
  assign dig      = digit_decode(ps2.data);
  assign fk       = fkey_decode(ps2.data);
  assign fk_ok    = fk[2] && (int'(fk[1:0]) < NUM_FIELDS);

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (make_vld && fk_ok) state_d = EDIT;
      EDIT: if (make_vld) begin
        if (ps2.data == 8'h76)      state_d = IDLE;
        else if (ps2.data == 8'h5A) state_d = (cnt_q == 3'd0) ? IDLE : CONVERT;
      end
      CONVERT: if (cyc_q == DIG_N - 3'd1) state_d = CHECK;
      CHECK:   state_d = in_range(acc_q) ? IDLE : EDIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      active_q <= '0;
      buf_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      acc_q    <= '0;
      values_q <= '0;
      fvalid_q <= '0;
      commit_q <= 1'b0;
      rerr_q   <= 1'b0;
      cfield_q <= '0;
    end else begin
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      active_q <= active_d;
      buf_q    <= buf_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      acc_q    <= acc_d;
      values_q <= values_d;
      fvalid_q <= fvalid_d;
      commit_q <= commit_d;
      rerr_q   <= rerr_d;
      cfield_q <= cfield_d;
    end
  end

  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    active_d = active_q;
    buf_d    = buf_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    acc_d    = acc_q;
    values_d = values_q;
    fvalid_d = fvalid_q;
    commit_d = 1'b0;
    rerr_d   = 1'b0;
    cfield_d = cfield_q;

    if (ps2.data_en) begin
      if (ps2.data == 8'hF0)      brk_d = 1'b1;
      else if (ps2.data == 8'hE0) ext_d = 1'b1;
      else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: if (make_vld && fk_ok) begin
        active_d = fk[1:0];
        buf_d    = '0;
        cnt_d    = '0;
      end
      EDIT: if (make_vld) begin
        if (dig[4]) begin
          if (cnt_q < DIG_N) begin
            buf_d = (buf_q << 4) | BW'(dig[3:0]);
            cnt_d = cnt_q + 3'd1;
          end
        end else if (ps2.data == 8'h66) begin
          if (cnt_q != 3'd0) begin
            buf_d = buf_q >> 4;
            cnt_d = cnt_q - 3'd1;
          end
        end else if (ps2.data == 8'h5A && cnt_q != 3'd0) begin
          // Convert from a copy so a rejected value leaves the edit buffer intact
          acc_d = '0;
          sh_d  = buf_q;
          cyc_d = '0;
        end
      end
      CONVERT: begin
        acc_d = bcd_mac(acc_q, sh_q[BW-1 -: 4]);
        sh_d  = sh_q << 4;
        cyc_d = cyc_q + 3'd1;
      end
      CHECK: begin
        if (in_range(acc_q)) begin
          values_d[active_q*VAL_W +: VAL_W] = acc_q;
          fvalid_d[active_q] = 1'b1;
          commit_d = 1'b1;
          cfield_d = active_q;
        end else begin
          rerr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    editing = (state_q != IDLE);
    for (int j = 0; j < DIGITS; j++) digit_blank[j] = (3'(j) >= cnt_q);
  end

  assign values       = values_q;
  assign field_valid  = fvalid_q;
  assign active_field = active_q;
  assign digits_bcd   = buf_q;
  assign commit       = commit_q;
  assign commit_field = cfield_q;
  assign range_error  = rerr_q;

endmodule

// File: tb/tb_ps2_field_entry.sv
// Directed bench for ps2_field_entry: a 3-field instance with a commit scoreboard,
// plus a 2-field instance for the function-key range limit.
module tb_ps2_field_entry;
  localparam int DIG = 3;

  logic clk, nReset;
  ps2_field_entry_if ifa ();
  ps2_field_entry_if ifb ();

  logic [29:0] values_a;
  logic [2:0]  fvalid_a, blank_a;
  logic        editing_a, commit_a, rerr_a;
  logic [1:0]  active_a, cfield_a;
  logic [11:0] bcd_a;

  logic [19:0] values_b;
  logic [1:0]  fvalid_b, active_b, cfield_b;
  logic [2:0]  blank_b;
  logic        editing_b, commit_b, rerr_b;
  logic [11:0] bcd_b;

  ps2_field_entry #(.NUM_FIELDS(3), .DIGITS(3), .VAL_W(10), .MIN_VAL(1), .MAX_VAL(999)) dut_a (
    .CLOCK_50(clk), .nReset(nReset), .ps2(ifa),
    .values(values_a), .field_valid(fvalid_a), .editing(editing_a), .active_field(active_a),
    .digits_bcd(bcd_a), .digit_blank(blank_a), .commit(commit_a), .commit_field(cfield_a),
    .range_error(rerr_a));

  ps2_field_entry #(.NUM_FIELDS(2), .DIGITS(3), .VAL_W(10), .MIN_VAL(1), .MAX_VAL(999)) dut_b (
    .CLOCK_50(clk), .nReset(nReset), .ps2(ifb),
    .values(values_b), .field_valid(fvalid_b), .editing(editing_b), .active_field(active_b),
    .digits_bcd(bcd_b), .digit_blank(blank_b), .commit(commit_b), .commit_field(cfield_b),
    .range_error(rerr_b));

  typedef struct {
    bit         err;
    logic [1:0] fld;
    logic [9:0] val;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   b_pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit to_b, input logic [7:0] code);
    @(negedge clk);
    if (to_b) begin ifb.data = code; ifb.data_en = 1'b1; end
    else      begin ifa.data = code; ifa.data_en = 1'b1; end
    @(negedge clk);
    ifa.data_en = 1'b0;
    ifb.data_en = 1'b0;
  endtask

  // Enter was taken at the edge just before this negedge; result is due DIG+1 edges later
  task automatic expect_out(input bit err, input logic [1:0] fld, input logic [9:0] val);
    exp_t e;
    e.err = err; e.fld = fld; e.val = val; e.cyc = cyc + DIG + 1;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (nReset && (commit_a || rerr_a)) begin
      chk("out_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e_mon = q.pop_front();
        chk("out_kind", {commit_a, rerr_a}, e_mon.err ? 2'b01 : 2'b10);
        chk("out_latency", cyc, e_mon.cyc);
        if (!e_mon.err) begin
          chk("commit_field", cfield_a, e_mon.fld);
          chk("commit_value", values_a[e_mon.fld*10 +: 10], e_mon.val);
        end
      end
    end
    if (nReset && (commit_b || rerr_b)) b_pulses++;
  end

  initial begin
    nReset = 1'b0;
    ifa.data = 8'h00; ifa.data_en = 1'b0;
    ifb.data = 8'h00; ifb.data_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_values", values_a, 0);
    chk("rst_fvalid", fvalid_a, 0);
    chk("rst_editing", editing_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_blank", blank_a, 3'b111);
    chk("rst_pulses", {commit_a, rerr_a, cfield_a, active_a}, 0);
    nReset = 1'b1;

    // F2, 1 2 0, Enter
    send(0, 8'h06);
    chk("f2_edit", {editing_a, active_a}, {1'b1, 2'd1});
    send(0, 8'h16); send(0, 8'h1E); send(0, 8'h45);
    chk("f2_bcd", bcd_a, 12'h120);
    send(0, 8'h5A);
    expect_out(0, 2'd1, 10'd120);
    chk("convert_editing", editing_a, 1);
    drain();
    chk("f2_value", values_a[19:10], 120);
    chk("f2_fvalid", fvalid_a, 3'b010);
    chk("f2_idle", editing_a, 0);

    // F1, 4 5 6 7 (overflow), Backspace, Enter
    send(0, 8'h05);
    send(0, 8'h25); send(0, 8'h2E); send(0, 8'h36); send(0, 8'h3D);
    chk("full_bcd", bcd_a, 12'h456);
    chk("full_blank", blank_a, 3'b000);
    send(0, 8'h66);
    chk("bs_bcd", bcd_a, 12'h045);
    chk("bs_blank", blank_a, 3'b100);
    send(0, 8'h5A);
    expect_out(0, 2'd0, 10'd45);
    drain();
    chk("f1_value", values_a[9:0], 45);
    chk("f1_fvalid", fvalid_a, 3'b011);
    chk("f1_other", values_a[19:10], 120);

    // F3, 0, Enter -> below MIN_VAL
    send(0, 8'h04); send(0, 8'h45); send(0, 8'h5A);
    expect_out(1, 2'd2, 10'd0);
    drain();
    chk("err_edit", {editing_a, active_a}, {1'b1, 2'd2});
    chk("err_bcd", bcd_a, 12'h000);
    chk("err_blank", blank_a, 3'b110);
    send(0, 8'h76);
    chk("esc_idle", editing_a, 0);
    chk("esc_value", values_a[29:20], 0);
    chk("esc_fvalid", fvalid_a[2], 0);

    // Break / extended filtering
    send(0, 8'h05); send(0, 8'h26);
    send(0, 8'hF0); send(0, 8'h26);
    send(0, 8'hE0); send(0, 8'h5A);
    chk("filt_bcd", bcd_a, 12'h003);
    chk("filt_blank", blank_a, 3'b110);
    chk("filt_editing", editing_a, 1);
    send(0, 8'h5A);
    expect_out(0, 2'd0, 10'd3);
    drain();
    chk("filt_value", values_a[9:0], 3);

    // Reset during CONVERT
    send(0, 8'h05); send(0, 8'h46); send(0, 8'h5A);
    nReset = 1'b0;
    #1;
    chk("mid_rst_values", values_a, 0);
    chk("mid_rst_state", {editing_a, commit_a, rerr_a, fvalid_a}, 0);
    chk("mid_rst_blank", blank_a, 3'b111);
    @(negedge clk);
    nReset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_values", values_a, 0);
    chk("post_rst_editing", editing_a, 0);

    // NUM_FIELDS=2: F3 ignored, empty Enter returns to IDLE silently
    send(1, 8'h04);
    chk("b_f3_ignored", editing_b, 0);
    send(1, 8'h05);
    chk("b_f1_edit", {editing_b, active_b}, {1'b1, 2'd0});
    send(1, 8'h5A);
    chk("b_empty_enter", editing_b, 0);
    repeat (6) @(negedge clk);
    chk("b_no_output", b_pulses, 0);
    chk("b_values", {values_b, fvalid_b}, 0);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
